// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: memory widths, access-size codes and default read latency
// shared by the arbiter, its interface and the pick logic.
package mem_port_arbiter_pkg;
    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int RD_LAT_DEFAULT = 2;
    typedef enum logic [1:0] {
        DW_BYTE  = 2'd0,
        DW_HALF  = 2'd1,
        DW_WORD  = 2'd2,
        DW_DWORD = 2'd3
    } dw_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side bus, flattened per requester, plus
// the grant and read-return signals.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DATA_W = MEM_DATA_WIDTH
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [2*N_REQ-1:0]      req_dw;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    modport master (output req, req_we, req_dw, req_addr, req_wdata, input gnt, rvalid, rdata);
    modport slave  (input req, req_we, req_dw, req_addr, req_wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: round-robin search starting at ptr, wrapping modulo N;
// returns the first requester found as a one-hot grant and an index.
module rr_priority_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    logic [IW:0] pos;
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        // scan from the farthest offset back so the nearest hit to ptr wins
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            pos = (pos >= (IW+1)'(N)) ? pos - (IW+1)'(N) : pos;
            if (req[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
                any = 1'b1;
            end
        end
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among N_REQ requesters;
// a valid/id shift register routes each read word back to the requester that issued it.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DATA_W = MEM_DATA_WIDTH,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output logic                 mem_we,
    output logic [1:0]           mem_dw,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_in,
    input  logic [DATA_W-1:0]    mem_out
);
    localparam int IW = $clog2(N_REQ);
    logic [IW-1:0]              rr_ptr_q, rr_ptr_d, pick_idx;
    logic [N_REQ-1:0]           pick_gnt;
    logic                       pick_any, quiet_q, take;
    logic [RD_LAT-1:0]          vld_q, vld_d;
    logic [RD_LAT-1:0][IW-1:0]  id_q, id_d;

    rr_priority_pick #(.N(N_REQ)) u_pick (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        // the port stays silent during reset and for one cycle after release
        take       = pick_any & ~reset & ~quiet_q;
        bus.gnt    = take ? pick_gnt : '0;
        mem_we     = take & bus.req_we[pick_idx];
        mem_dw     = take ? bus.req_dw[2*pick_idx +: 2] : DW_BYTE;
        mem_addr   = take ? bus.req_addr[ADDR_W*pick_idx +: ADDR_W] : '0;
        mem_in     = take ? bus.req_wdata[DATA_W*pick_idx +: DATA_W] : '0;
        rr_ptr_d   = !take ? rr_ptr_q : (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        vld_d[0]   = take & ~bus.req_we[pick_idx];
        id_d[0]    = pick_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
        bus.rvalid = (vld_q[RD_LAT-1] & ~reset) ? N_REQ'(1) << id_q[RD_LAT-1] : '0;
        bus.rdata  = mem_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            quiet_q  <= 1'b1;
            vld_q    <= '0;
            id_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            quiet_q  <= 1'b0;
            vld_q    <= vld_d;
            id_q     <= id_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a reference
// model; expected reads go to a queue that a separate monitor pops against rvalid.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int AW  = MEM_ADDR_WIDTH;
    localparam int DW  = MEM_DATA_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_we;
    logic [1:0] mem_dw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in, mem_out;

    mem_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_we   (mem_we),
        .mem_dw   (mem_dw),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clk = ~clk;

    // memory port environment with LAT-cycle read latency
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[7:0]] <= mem_in;
        pipe[0] <= mem_arr[mem_addr[7:0]];
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign mem_out = pipe[LAT-1];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;
    rd_t           exp_q[$];
    logic [DW-1:0] ref_mem [256];
    int            m_ptr = 0;
    bit            m_quiet = 1'b1;
    int            cyc = 0;
    logic [N-1:0]  last_gnt = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // predictor: arbitration rule, memory-port mux and expected read returns
    always @(negedge clk) begin
        int w, wi;
        logic [AW-1:0] a;
        w = -1;
        if (!reset && !m_quiet)
            for (int k = 0; k < N; k++)
                if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        wi = (w < 0) ? 0 : w;
        chk("gnt", 64'(bus.gnt), (w < 0) ? 64'd0 : 64'd1 << w);
        chk("mem_we", 64'(mem_we), (w < 0) ? 64'd0 : 64'(bus.req_we[wi]));
        chk("mem_dw", 64'(mem_dw), (w < 0) ? 64'd0 : 64'(bus.req_dw[2*wi +: 2]));
        chk("mem_addr", 64'(mem_addr), (w < 0) ? 64'd0 : 64'(bus.req_addr[wi*AW +: AW]));
        chk("mem_in", 64'(mem_in), (w < 0) ? 64'd0 : 64'(bus.req_wdata[wi*DW +: DW]));
        if (reset) m_ptr = 0;
        else if (w >= 0) begin
            m_ptr = (w + 1) % N;
            a = bus.req_addr[w*AW +: AW];
            if (bus.req_we[w]) ref_mem[a[7:0]] = bus.req_wdata[w*DW +: DW];
            else exp_q.push_back('{cyc + LAT, w, ref_mem[a[7:0]]});
        end
        m_quiet = reset;
        last_gnt = bus.gnt;
    end

    // monitor: read returns must match the queue head exactly on its due cycle
    always @(negedge clk) begin
        rd_t e;
        if (reset) begin
            chk("rvalid_reset", 64'(bus.rvalid), 64'd0);
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rvalid", 64'(bus.rvalid), 64'd1 << e.id);
            chk("rdata", 64'(bus.rdata), 64'(e.data));
        end else begin
            chk("rvalid_idle", 64'(bus.rvalid), 64'd0);
        end
    end

    task automatic set_req(int i, bit on, bit we, int addr, logic [DW-1:0] d);
        bus.req[i] = on;
        bus.req_we[i] = we;
        bus.req_dw[2*i +: 2] = DW_WORD;
        bus.req_addr[i*AW +: AW] = AW'(addr);
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // give every just-granted requester in mask a fresh random access
    task automatic refresh(logic [N-1:0] mask, bit rd_only);
        for (int i = 0; i < N; i++)
            if (mask[i] && last_gnt[i])
                set_req(i, 1'b1, rd_only ? 1'b0 : 1'($urandom_range(0, 1)),
                        $urandom_range(0, 63), $urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, '0);
        reset = 1'b1;
        step(4);
        reset = 1'b0;
        step(4);
        clear_all();
        step(2);
        // lone read from requester 1 of the preloaded word
        set_req(1, 1'b1, 1'b0, 'h10, '0);
        step(1);
        clear_all();
        step(3);
        // two requesters streaming reads
        set_req(0, 1'b1, 1'b0, 3, '0);
        set_req(1, 1'b1, 1'b0, 5, '0);
        repeat (8) begin
            step(1);
            refresh(4'b0011, 1'b1);
        end
        clear_all();
        step(3);
        // write then read-back through a different requester
        set_req(0, 1'b1, 1'b1, 'h20, 32'h1234);
        step(1);
        clear_all();
        set_req(1, 1'b1, 1'b0, 'h20, '0);
        step(1);
        clear_all();
        step(4);
        // reset one cycle after a granted read drops the return
        set_req(1, 1'b1, 1'b0, 'h10, '0);
        step(1);
        clear_all();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 1, '0);
        set_req(1, 1'b1, 1'b0, 2, '0);
        step(3);
        clear_all();
        step(3);
        // requesters 1 and 3 with the pointer parked at 2
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        set_req(1, 1'b1, 1'b0, 7, '0);
        step(1);
        set_req(3, 1'b1, 1'b0, 9, '0);
        refresh(4'b1010, 1'b1);
        repeat (4) begin
            step(1);
            refresh(4'b1010, 1'b1);
        end
        clear_all();
        step(3);
        // random traffic with held, withdrawn and replaced requests and occasional resets
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !last_gnt[i] && $urandom_range(0, 9) != 0) continue;
                if ($urandom_range(0, 2) == 0) bus.req[i] = 1'b0;
                else begin
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom);
                    bus.req_dw[2*i +: 2] = 2'($urandom_range(0, 3));
                end
            end
            step(1);
        end
        reset = 1'b0;
        clear_all();
        step(LAT + 4);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads still expected", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
